// File: rtl/ara_inval_sequencer_if.sv
// Burst-descriptor and invalidation-request bundle between the Ara store path,
// the invalidation sequencer and the CVA6 cache-invalidation port.
`default_nettype none

interface ara_inval_sequencer_if #(
  parameter int AddrWidth = 64
);
  logic                 en_i;
  logic                 burst_valid_i;
  logic                 burst_ready_o;
  logic [AddrWidth-1:0] burst_addr_i;
  logic [7:0]           burst_len_i;
  logic [2:0]           burst_size_i;
  logic                 inval_valid_o;
  logic                 inval_ready_i;
  logic [AddrWidth-1:0] inval_addr_o;
  logic                 busy_o;

  // master drives descriptors and accepts invalidations; slave is the sequencer
  modport master (
    output en_i, burst_valid_i, burst_addr_i, burst_len_i, burst_size_i, inval_ready_i,
    input  burst_ready_o, inval_valid_o, inval_addr_o, busy_o
  );

  modport slave (
    input  en_i, burst_valid_i, burst_addr_i, burst_len_i, burst_size_i, inval_ready_i,
    output burst_ready_o, inval_valid_o, inval_addr_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/ara_inval_sequencer.sv
// Expands Ara AW-burst descriptors into per-L1-line invalidation requests for
// CVA6, with a descriptor FIFO, duplicate-line suppression and enable flushing.
`default_nettype none

module ara_inval_sequencer #(
  parameter int AddrWidth   = 64,
  parameter int L1LineBytes = 16,
  parameter int Depth       = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  ara_inval_sequencer_if.slave   bus
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(L1LineBytes - 1);
  localparam logic [AddrWidth-1:0] LineStep = AddrWidth'(L1LineBytes);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // descriptor FIFO
  logic [AddrWidth-1:0] mem_addr [Depth];
  logic [7:0]           mem_len  [Depth];
  logic [2:0]           mem_size [Depth];
  logic [PtrW:0]        wptr, rptr;
  logic                 fifo_full, fifo_empty, push, pop, flush;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[PtrW] != rptr[PtrW]) && (wptr[PtrW-1:0] == rptr[PtrW-1:0]);

  // with coherence off, descriptors are swallowed so the vector store path never stalls
  assign bus.burst_ready_o = rst_ni && (!bus.en_i || !fifo_full);
  assign push = bus.burst_valid_i && bus.burst_ready_o && bus.en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= wptr;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr[wptr[PtrW-1:0]] <= bus.burst_addr_i;
      mem_len[wptr[PtrW-1:0]]  <= bus.burst_len_i;
      mem_size[wptr[PtrW-1:0]] <= bus.burst_size_i;
    end
  end

  // line range of the head descriptor, one extra bit to catch wrap past the top
  logic [AddrWidth-1:0] head_addr, start_line, last_byte, end_line_calc;
  logic [AddrWidth:0]   burst_bytes, last_byte_ext;

  assign head_addr     = mem_addr[rptr[PtrW-1:0]];
  assign burst_bytes   = {{(AddrWidth-8){1'b0}}, (9'(mem_len[rptr[PtrW-1:0]]) + 9'd1)}
                         << mem_size[rptr[PtrW-1:0]];
  assign last_byte_ext = {1'b0, head_addr} + burst_bytes - (AddrWidth+1)'(1);
  assign last_byte     = last_byte_ext[AddrWidth] ? '1 : last_byte_ext[AddrWidth-1:0];
  assign start_line    = head_addr & LineMask;
  assign end_line_calc = last_byte & LineMask;

  state_t               state, state_n;
  logic [AddrWidth-1:0] cur_line, cur_line_n, end_line, end_line_n, last_line, last_line_n;
  logic                 dedup_valid, dedup_valid_n, dup, advance, inval_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cur_line    <= '0;
      end_line    <= '0;
      last_line   <= '0;
      dedup_valid <= 1'b0;
    end else begin
      state       <= state_n;
      cur_line    <= cur_line_n;
      end_line    <= end_line_n;
      last_line   <= last_line_n;
      dedup_valid <= dedup_valid_n;
    end
  end

  assign dup = dedup_valid && (cur_line == last_line);

  always_comb begin
    state_n       = state;
    cur_line_n    = cur_line;
    end_line_n    = end_line;
    last_line_n   = last_line;
    dedup_valid_n = dedup_valid;
    pop           = 1'b0;
    flush         = 1'b0;
    advance       = 1'b0;
    inval_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.en_i) begin
          flush         = 1'b1;
          dedup_valid_n = 1'b0;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          cur_line_n = start_line;
          end_line_n = end_line_calc;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        inval_valid = !dup;
        if (dup) begin
          advance = 1'b1;
        end else if (bus.inval_ready_i) begin
          advance       = 1'b1;
          last_line_n   = cur_line;
          dedup_valid_n = 1'b1;
        end
        // an offered request is never withdrawn; the flush waits for its handshake
        if (!bus.en_i && advance) begin
          flush         = 1'b1;
          dedup_valid_n = 1'b0;
          state_n       = IDLE;
        end else if (advance) begin
          if (cur_line == end_line) state_n = IDLE;
          else                      cur_line_n = cur_line + LineStep;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.inval_valid_o = inval_valid;
  assign bus.inval_addr_o  = cur_line;
  assign bus.busy_o        = !fifo_empty || (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ara_inval_sequencer.sv
// Scenario bench for ara_inval_sequencer: directed cases plus randomized bursts
// checked against a line-range reference model with duplicate suppression.
`default_nettype none

module tb_ara_inval_sequencer;
  localparam int LINE = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  logic [63:0] got[$];
  logic [63:0] exp[$];
  logic [63:0] m_last;
  logic        m_dv;

  ara_inval_sequencer_if #(.AddrWidth(64)) bus ();

  ara_inval_sequencer #(.AddrWidth(64), .L1LineBytes(LINE), .Depth(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // handshake monitor: inputs settle well before negedge+3
  initial forever begin
    @(negedge clk);
    #3;
    if (rst_n && bus.inval_valid_o && bus.inval_ready_i) got.push_back(bus.inval_addr_o);
  end

  task automatic model_accept(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
    logic [64:0] lb;
    logic [63:0] line, last;
    if (!bus.en_i) return;
    lb = {1'b0, a} + ((65'(l) + 65'd1) << s) - 65'd1;
    if (lb[64]) lb = {1'b0, {64{1'b1}}};
    line = a - (a % LINE);
    last = lb[63:0] - (lb[63:0] % LINE);
    forever begin
      if (!(m_dv && m_last == line)) exp.push_back(line);
      m_last = line;
      m_dv   = 1'b1;
      if (line == last) break;
      line = line + LINE;
    end
  endtask

  task automatic drive_burst(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
    int n;
    @(negedge clk);
    bus.burst_valid_i = 1'b1;
    bus.burst_addr_i  = a;
    bus.burst_len_i   = l;
    bus.burst_size_i  = s;
    #1;
    for (n = 0; n < 300 && !bus.burst_ready_o; n++) begin
      @(negedge clk);
      #1;
    end
    total++;
    if (n >= 300) $display("FAIL burst_accept_timeout addr=%h ready=%b required=1", a, bus.burst_ready_o);
    else passed++;
    @(posedge clk);
    model_accept(a, l, s);
    #1 bus.burst_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.en_i = 1'b1;
    bus.burst_valid_i = 1'b0;
    bus.burst_addr_i = '0;
    bus.burst_len_i = '0;
    bus.burst_size_i = '0;
    bus.inval_ready_i = 1'b1;
    m_dv = 1'b0;
    m_last = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.burst_ready_o !== 1'b0) $display("FAIL reset_burst_ready got=%b exp=0", bus.burst_ready_o); else passed++;
    total++; if (bus.inval_valid_o !== 1'b0) $display("FAIL reset_inval_valid got=%b exp=0", bus.inval_valid_o); else passed++;
    total++; if (bus.inval_addr_o !== 64'h0) $display("FAIL reset_inval_addr got=%h exp=0", bus.inval_addr_o); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy_o); else passed++;
    @(negedge clk) rst_n = 1'b1;
    #1;
    total++; if (bus.burst_ready_o !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", bus.burst_ready_o); else passed++;
  endtask

  task automatic test_single_burst;
    logic [3:0] v;
    logic [63:0] a2, a3;
    got.delete(); exp.delete();
    bus.inval_ready_i = 1'b1;
    drive_burst(64'h1000, 8'd3, 3'd3);
    @(negedge clk); #1 v[0] = bus.inval_valid_o;
    @(negedge clk); #1 v[1] = bus.inval_valid_o; a2 = bus.inval_addr_o;
    @(negedge clk); #1 v[2] = bus.inval_valid_o; a3 = bus.inval_addr_o;
    @(negedge clk); #1 v[3] = bus.inval_valid_o;
    total++; if (v !== 4'b0110) $display("FAIL latency_valid_pattern got=%b exp=0110", v); else passed++;
    total++; if (a2 !== 64'h1000 || a3 !== 64'h1010) $display("FAIL single_addrs got=%h,%h exp=1000,1010", a2, a3); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL busy_after_last got=%b exp=0", bus.busy_o); else passed++;
    total++; if (got.size() != exp.size()) $display("FAIL single_count got=%0d exp=%0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("FAIL single_line[%0d] got=%h exp=%h", i, got[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_unaligned_and_dedup;
    int n;
    got.delete(); exp.delete();
    drive_burst(64'h100C, 8'd0, 3'd3);
    drive_burst(64'h2000, 8'd0, 3'd3);
    drive_burst(64'h2008, 8'd0, 3'd3);
    for (n = 0; n < 500 && bus.busy_o; n++) @(negedge clk);
    total++; if (bus.busy_o) $display("FAIL dedup_drain_timeout busy=%b exp=0", bus.busy_o); else passed++;
    total++; if (got.size() != 3 || exp.size() != 3) $display("FAIL dedup_count got=%0d model=%0d exp=3", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("FAIL dedup_line[%0d] got=%h exp=%h", i, got[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_backpressure;
    int acc, n;
    logic stable, seen;
    got.delete(); exp.delete();
    bus.inval_ready_i = 1'b0;
    acc = 0; stable = 1'b1; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.burst_valid_i = (acc < 6);
      bus.burst_addr_i  = 64'h4000 + 64'(acc * 16);
      bus.burst_len_i   = 8'd0;
      bus.burst_size_i  = 3'd3;
      #1;
      if (bus.inval_valid_o) begin
        seen = 1'b1;
        if (bus.inval_addr_o !== 64'h4000) stable = 1'b0;
      end
      if (bus.burst_valid_i && bus.burst_ready_o) begin
        @(posedge clk);
        model_accept(bus.burst_addr_i, 8'd0, 3'd3);
        acc++;
      end
    end
    @(negedge clk);
    #1;
    total++; if (acc != 5) $display("FAIL bp_accepted got=%0d exp=5", acc); else passed++;
    total++; if (bus.burst_ready_o !== 1'b0) $display("FAIL bp_ready_low got=%b exp=0", bus.burst_ready_o); else passed++;
    total++; if (!seen || !stable) $display("FAIL bp_addr_stable seen=%b stable=%b exp=1,1", seen, stable); else passed++;
    bus.burst_valid_i = 1'b0;
    bus.inval_ready_i = 1'b1;
    for (n = 0; n < 500 && bus.busy_o; n++) @(negedge clk);
    total++; if (got.size() != 5 || exp.size() != 5) $display("FAIL bp_count got=%0d model=%0d exp=5", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("FAIL bp_line[%0d] got=%h exp=%h", i, got[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_en_drop;
    int n;
    got.delete(); exp.delete();
    bus.inval_ready_i = 1'b0;
    drive_burst(64'h3000, 8'd0, 3'd3);
    drive_burst(64'h3100, 8'd0, 3'd3);
    drive_burst(64'h3200, 8'd0, 3'd3);
    drive_burst(64'h3300, 8'd0, 3'd3);
    for (n = 0; n < 50 && !bus.inval_valid_o; n++) @(negedge clk);
    @(negedge clk);
    bus.en_i = 1'b0;
    #1;
    total++; if (bus.inval_valid_o !== 1'b1 || bus.inval_addr_o !== 64'h3000)
      $display("FAIL endrop_hold got=%b/%h exp=1/3000", bus.inval_valid_o, bus.inval_addr_o); else passed++;
    @(negedge clk);
    bus.inval_ready_i = 1'b1;
    #1;
    total++; if (bus.inval_valid_o !== 1'b1) $display("FAIL endrop_hold2 got=%b exp=1", bus.inval_valid_o); else passed++;
    @(negedge clk);
    #1;
    total++; if (bus.inval_valid_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL endrop_flush valid=%b busy=%b exp=0,0", bus.inval_valid_o, bus.busy_o); else passed++;
    // queued descriptors are flushed along with model dedup state
    exp.delete();
    exp.push_back(64'h3000);
    m_dv = 1'b0;
    total++; if (bus.burst_ready_o !== 1'b1) $display("FAIL disabled_ready got=%b exp=1", bus.burst_ready_o); else passed++;
    drive_burst(64'h5000, 8'd2, 3'd3);
    repeat (5) @(negedge clk);
    #1;
    total++; if (bus.busy_o !== 1'b0 || bus.inval_valid_o !== 1'b0)
      $display("FAIL disabled_ignored busy=%b valid=%b exp=0,0", bus.busy_o, bus.inval_valid_o); else passed++;
    total++; if (got.size() != 1 || got[0] !== 64'h3000) $display("FAIL endrop_lines count=%0d exp=1 (3000)", got.size()); else passed++;
    bus.en_i = 1'b1;
  endtask

  task automatic test_overflow;
    int n;
    got.delete(); exp.delete();
    bus.inval_ready_i = 1'b1;
    drive_burst(64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3);
    for (n = 0; n < 500 && bus.busy_o; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    total++; if (got.size() != 1 || exp.size() != 1) $display("FAIL overflow_count got=%0d model=%0d exp=1", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("FAIL overflow_line[%0d] got=%h exp=%h", i, got[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_async_reset;
    int n;
    got.delete(); exp.delete();
    bus.inval_ready_i = 1'b0;
    drive_burst(64'h6000, 8'd7, 3'd3);
    drive_burst(64'h7000, 8'd0, 3'd3);
    for (n = 0; n < 50 && !bus.inval_valid_o; n++) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.inval_valid_o !== 1'b0 || bus.burst_ready_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL async_reset valid=%b ready=%b busy=%b exp=0,0,0", bus.inval_valid_o, bus.burst_ready_o, bus.busy_o); else passed++;
    @(negedge clk) rst_n = 1'b1;
    exp.delete();
    m_dv = 1'b0;
    bus.inval_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    total++; if (got.size() != 0 || bus.busy_o !== 1'b0)
      $display("FAIL reset_no_replay lines=%0d busy=%b exp=0,0", got.size(), bus.busy_o); else passed++;
  endtask

  task automatic test_random;
    int n;
    logic done;
    got.delete(); exp.delete();
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++)
          drive_burst(64'h8000 + 64'($urandom_range(0, 15) * 8), 8'($urandom_range(0, 3)), 3'($urandom_range(0, 3)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.inval_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.inval_ready_i = 1'b1;
    for (n = 0; n < 2000 && bus.busy_o; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    total++; if (got.size() != exp.size()) $display("FAIL random_count got=%0d exp=%0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("FAIL random_line[%0d] got=%h exp=%h", i, got[i], exp[i]); else passed++;
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_single_burst();
    test_unaligned_and_dedup();
    test_backpressure();
    test_en_drop();
    test_overflow();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
